clb_tile_cfg_loader: RTL and testbench

//  Word-level configuration loader for the CLB tile shift chains. Accepts config words over a

---
 rtl/clb_tile_cfg_loader_if.sv | 27 ++
 rtl/clb_tile_cfg_loader.sv | 199 +++++++++++++++++++
 tb/tb_clb_tile_cfg_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/clb_tile_cfg_loader_if.sv
// Config word input and readback word output of the CLB tile loader.
// The loader is the slave: it accepts cfg words and produces readback words.
interface clb_tile_cfg_loader_if #(
    parameter int WORD_W = 32
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              rb_valid;
    logic [WORD_W-1:0] rb_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready,
        input  rb_valid,
        input  rb_data
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready,
        output rb_valid,
        output rb_data
    );
endinterface

// File: rtl/clb_tile_cfg_loader.sv
// Word-level loader for NUM_CHAINS parallel CLB shift chains.
// Each accepted word is spread over WORD_W/NUM_CHAINS shift steps, LSB first,
// bit i going to chain (i % NUM_CHAINS). Tail bits are packed back the same way
// into readback words. After CHAIN_LEN steps set_out commits the chains.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// LOAD  | cfg_ready high, waiting for the next word
// SHIFT | chain_en high, one shift step per cycle
// SET   | set_out high for SET_PULSE cycles
// DONE  | done pulse, back to IDLE
module clb_tile_cfg_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 160,
    parameter int WORD_W     = 32,
    parameter int SET_PULSE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  start,
    input  logic                  abort,
    clb_tile_cfg_loader_if.slave  cfg_if,
    output logic [NUM_CHAINS-1:0] chain_data,
    output logic                  chain_en,
    input  logic [NUM_CHAINS-1:0] chain_tail,
    output logic                  set_out,
    output logic                  busy,
    output logic                  done
);

    localparam int S    = WORD_W / NUM_CHAINS;
    localparam int WS_W = (S > 1) ? $clog2(S) : 1;
    localparam int SC_W = $clog2(CHAIN_LEN + 1);
    localparam int PC_W = (SET_PULSE > 1) ? $clog2(SET_PULSE) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        SET   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [WS_W-1:0]       wstep_q, wstep_d;
    logic [SC_W-1:0]       steps_q, steps_d;
    logic [WORD_W-1:0]     rbacc_q, rbacc_d;
    logic [PC_W-1:0]       set_cnt_q, set_cnt_d;
    logic [NUM_CHAINS-1:0] chain_data_q, chain_data_d;
    logic                  chain_en_q, chain_en_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  set_out_q, set_out_d;
    logic                  rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0]     rb_data_q, rb_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [WORD_W-1:0]     word_next_chunk;
    logic [WORD_W-1:0]     rb_word;
    logic                  last_step;

    // Next state and next registered outputs; everything is computed one cycle ahead.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        wstep_d      = wstep_q;
        steps_d      = steps_q;
        rbacc_d      = rbacc_q;
        set_cnt_d    = set_cnt_q;
        rb_data_d    = rb_data_q;
        chain_data_d = '0;
        chain_en_d   = 1'b0;
        cfg_ready_d  = 1'b0;
        set_out_d    = 1'b0;
        rb_valid_d   = 1'b0;
        done_d       = 1'b0;

        word_next_chunk = word_q >> (NUM_CHAINS * (int'(wstep_q) + 1));
        // tail bit sampled on the edge this step shifts, i.e. pre-shift tail
        rb_word   = rbacc_q | (WORD_W'(chain_tail) << (NUM_CHAINS * int'(wstep_q)));
        last_step = (wstep_q == WS_W'(S - 1)) || (steps_q == SC_W'(CHAIN_LEN - 1));

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            wstep_d   = '0;
            steps_d   = '0;
            rbacc_d   = '0;
            set_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d     = LOAD;
                        cfg_ready_d = 1'b1;
                        steps_d     = '0;
                    end
                end
                LOAD: begin
                    if (cfg_if.cfg_valid && cfg_ready_q) begin
                        state_d      = SHIFT;
                        word_d       = cfg_if.cfg_data;
                        wstep_d      = '0;
                        rbacc_d      = '0;
                        chain_data_d = cfg_if.cfg_data[NUM_CHAINS-1:0];
                        chain_en_d   = 1'b1;
                    end else begin
                        cfg_ready_d = 1'b1;
                    end
                end
                SHIFT: begin
                    steps_d = steps_q + SC_W'(1);
                    rbacc_d = rb_word;
                    if (last_step) begin
                        rb_valid_d = 1'b1;
                        rb_data_d  = rb_word;
                        wstep_d    = '0;
                        if (steps_q == SC_W'(CHAIN_LEN - 1)) begin
                            state_d   = SET;
                            set_out_d = 1'b1;
                            set_cnt_d = PC_W'(SET_PULSE - 1);
                        end else begin
                            state_d     = LOAD;
                            cfg_ready_d = 1'b1;
                        end
                    end else begin
                        wstep_d      = wstep_q + WS_W'(1);
                        chain_data_d = word_next_chunk[NUM_CHAINS-1:0];
                        chain_en_d   = 1'b1;
                    end
                end
                SET: begin
                    if (set_cnt_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        set_cnt_d = set_cnt_q - PC_W'(1);
                        set_out_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    steps_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; cen low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            wstep_q      <= '0;
            steps_q      <= '0;
            rbacc_q      <= '0;
            set_cnt_q    <= '0;
            chain_data_q <= '0;
            chain_en_q   <= 1'b0;
            cfg_ready_q  <= 1'b0;
            set_out_q    <= 1'b0;
            rb_valid_q   <= 1'b0;
            rb_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (cen) begin
            state_q      <= state_d;
            word_q       <= word_d;
            wstep_q      <= wstep_d;
            steps_q      <= steps_d;
            rbacc_q      <= rbacc_d;
            set_cnt_q    <= set_cnt_d;
            chain_data_q <= chain_data_d;
            chain_en_q   <= chain_en_d;
            cfg_ready_q  <= cfg_ready_d;
            set_out_q    <= set_out_d;
            rb_valid_q   <= rb_valid_d;
            rb_data_q    <= rb_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign chain_data       = chain_data_q;
    assign chain_en         = chain_en_q;
    assign cfg_if.cfg_ready = cfg_ready_q;
    assign set_out          = set_out_q;
    assign cfg_if.rb_valid  = rb_valid_q;
    assign cfg_if.rb_data   = rb_data_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_clb_tile_cfg_loader.sv
// Scoreboard bench for clb_tile_cfg_loader with 4 chains of 5 bits, 8-bit words.
module tb_clb_tile_cfg_loader;
    localparam int NC = 4;
    localparam int CL = 5;
    localparam int WW = 8;
    localparam int SP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cen = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NC-1:0] chain_tail = '0;
    logic [NC-1:0] chain_data;
    logic          chain_en, set_out, busy, done;

    clb_tile_cfg_loader_if #(.WORD_W(WW)) cfg_if();

    clb_tile_cfg_loader #(
        .NUM_CHAINS(NC), .CHAIN_LEN(CL), .WORD_W(WW), .SET_PULSE(SP)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .abort(abort),
        .cfg_if(cfg_if), .chain_data(chain_data), .chain_en(chain_en),
        .chain_tail(chain_tail), .set_out(set_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [NC-1:0] exp_chain_q[$];
    logic [WW-1:0] exp_rb_q[$];
    logic [NC-1:0] tail_tab[CL];
    int            k = 0;
    int            set_seen = 0;
    int            done_seen = 0;
    int            set_base, done_base;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tab(logic [NC-1:0] t0, t1, t2, t3, t4);
        tail_tab[0] = t0; tail_tab[1] = t1; tail_tab[2] = t2;
        tail_tab[3] = t3; tail_tab[4] = t4;
        k = 0;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        set_base  = set_seen;
        done_base = done_seen;
    endtask

    // Returns #1 after the accepting edge (first SHIFT cycle).
    task automatic send_word(logic [WW-1:0] w);
        logic ok;
        ok = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = w;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (cfg_if.cfg_ready && cen) ok = 1'b1;
        end
        chk("cfg handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60 && busy; c++) @(negedge clk);
        @(negedge clk);
        chk("busy low at end", 32'(busy), 32'd0);
    endtask

    task automatic end_checks(string name, int exp_set, int exp_done);
        chk({name, " set_out cycles"}, 32'(set_seen - set_base), 32'(exp_set));
        chk({name, " done pulses"}, 32'(done_seen - done_base), 32'(exp_done));
        chk({name, " chain queue left"}, 32'(exp_chain_q.size()), 32'd0);
        chk({name, " rb queue left"}, 32'(exp_rb_q.size()), 32'd0);
        exp_chain_q.delete();
        exp_rb_q.delete();
    endtask

    task automatic push_full_load();
        exp_chain_q.push_back(4'h5); exp_chain_q.push_back(4'hA);
        exp_chain_q.push_back(4'hC); exp_chain_q.push_back(4'h3);
        exp_chain_q.push_back(4'hF);
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        set_tab(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        fork
            forever begin
                @(negedge clk);
                if (rst && cen) begin
                    if (chain_en) begin
                        chain_tail = (k < CL) ? tail_tab[k] : '0;
                        k++;
                        if (exp_chain_q.size() == 0)
                            chk("chain_en unexpected", 32'(chain_en), 32'd0);
                        else
                            chk("chain_data", 32'(chain_data), 32'(exp_chain_q.pop_front()));
                    end
                    if (cfg_if.rb_valid) begin
                        if (exp_rb_q.size() == 0)
                            chk("rb_valid unexpected", 32'(cfg_if.rb_valid), 32'd0);
                        else
                            chk("rb_data", 32'(cfg_if.rb_data), 32'(exp_rb_q.pop_front()));
                    end
                    if (set_out) set_seen++;
                    if (done) done_seen++;
                end
            end
        join_none

        // reset state
        #12;
        chk("rst chain_en", 32'(chain_en), 32'd0);
        chk("rst chain_data", 32'(chain_data), 32'd0);
        chk("rst set_out", 32'(set_out), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("rst rb_valid", 32'(cfg_if.rb_valid), 32'd0);
        @(negedge clk); rst = 1'b1;

        // start together with abort in IDLE is ignored
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);

        // test 1/2: back-to-back full load, tails 1..5
        set_tab(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        push_full_load();
        exp_rb_q.push_back(8'h21); exp_rb_q.push_back(8'h43); exp_rb_q.push_back(8'h05);
        do_start();
        chk("t1 busy in LOAD", 32'(busy), 32'd1);
        send_word(8'hA5); send_word(8'h3C); send_word(8'hFF);
        wait_idle();
        end_checks("t1", 2, 1);

        // test 3: cfg_valid low for 4 cycles after first word; start while busy ignored
        set_tab(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        push_full_load();
        exp_rb_q.push_back(8'h21); exp_rb_q.push_back(8'h43); exp_rb_q.push_back(8'h05);
        do_start();
        send_word(8'hA5);
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3 stall cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
            chk("t3 stall chain_en", 32'(chain_en), 32'd0);
            chk("t3 stall steps", 32'(dut.steps_q), 32'd2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        send_word(8'h3C); send_word(8'hFF);
        wait_idle();
        end_checks("t3", 2, 1);

        // test 4: abort on second SHIFT cycle of word 2
        set_tab(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        exp_chain_q.push_back(4'h5); exp_chain_q.push_back(4'hA);
        exp_chain_q.push_back(4'hC); exp_chain_q.push_back(4'h3);
        exp_rb_q.push_back(8'h21);
        do_start();
        send_word(8'hA5); send_word(8'h3C);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t4 busy after abort", 32'(busy), 32'd0);
        chk("t4 chain_en after abort", 32'(chain_en), 32'd0);
        chk("t4 cfg_ready after abort", 32'(cfg_if.cfg_ready), 32'd0);
        chk("t4 steps cleared", 32'(dut.steps_q), 32'd0);
        repeat (4) @(negedge clk);
        end_checks("t4", 0, 0);

        // test 5: cen low for 3 cycles mid-SHIFT, tails 9,6,E,1,7
        set_tab(4'h9, 4'h6, 4'hE, 4'h1, 4'h7);
        push_full_load();
        exp_rb_q.push_back(8'h69); exp_rb_q.push_back(8'h1E); exp_rb_q.push_back(8'h07);
        do_start();
        send_word(8'hA5);
        cen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5 frozen chain_en", 32'(chain_en), 32'd1);
            chk("t5 frozen chain_data", 32'(chain_data), 32'h5);
            @(posedge clk); #1;
        end
        cen = 1'b1;
        send_word(8'h3C); send_word(8'hFF);
        wait_idle();
        end_checks("t5", 2, 1);

        // test 6: async reset during SET, then a clean reload
        set_tab(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        push_full_load();
        exp_rb_q.push_back(8'h21); exp_rb_q.push_back(8'h43); exp_rb_q.push_back(8'h05);
        do_start();
        send_word(8'hA5); send_word(8'h3C); send_word(8'hFF);
        for (int c = 0; c < 20 && !set_out; c++) @(negedge clk);
        chk("t6 set_out reached", 32'(set_out), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6 set_out on reset", 32'(set_out), 32'd0);
        chk("t6 busy on reset", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b1;
        end_checks("t6 aborted", 1, 0);

        set_tab(4'h9, 4'h6, 4'hE, 4'h1, 4'h7);
        push_full_load();
        exp_rb_q.push_back(8'h69); exp_rb_q.push_back(8'h1E); exp_rb_q.push_back(8'h07);
        do_start();
        send_word(8'hA5); send_word(8'h3C); send_word(8'hFF);
        wait_idle();
        end_checks("t6 reload", 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
